com_gesture_ctrl: RTL and testbench

COM_GESTURE_CTRL -- requirements
Module: com_gesture_ctrl

---
 rtl/com_gesture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_com_gesture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/com_gesture_ctrl.sv
// Turns centre-of-mass samples into debounced rotate commands: classify, hold, fire, cool down, wait for re-centre.
// Command strobe appears one cycle after the sample strobe that completes the hold; no backpressure.
module com_gesture_ctrl #(
    parameter int CENTER_X        = 512,
    parameter int CENTER_Y        = 384,
    parameter int DEAD_ZONE       = 96,
    parameter int HOLD_FRAMES     = 4,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        frame_start_in,
    input  logic        com_valid_in,
    input  logic [10:0] x_com_in,
    input  logic [9:0]  y_com_in,
    output logic [1:0]  rotate_out,
    output logic        rotate_valid_out,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ARM         = 3'd1,
        S_FIRE        = 3'd2,
        S_COOLDOWN    = 3'd3,
        S_WAIT_CENTER = 3'd4
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [3:0]  LP_HOLD = 4'(HOLD_FRAMES);
    localparam logic [7:0]  LP_CD   = 8'(COOLDOWN_FRAMES);
    localparam logic [11:0] LP_DZ   = 12'(DEAD_ZONE);

    logic [11:0] w_dx;
    logic [10:0] w_dy;
    logic [11:0] w_adx;
    logic [10:0] w_ady;
    logic        w_none;
    logic [1:0]  w_dir;
    logic [3:0]  w_cnt_nxt;
    logic [7:0]  w_cd_nxt;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_cd;
    logic [1:0]  r_cand;
    logic        r_samp_vld;
    logic        r_samp_none;
    logic [1:0]  r_samp_dir;
    logic        r_seen;
    logic [1:0]  r_rot;
    logic        r_rot_vld;

    assign w_dx  = {1'b0, x_com_in} - 12'(CENTER_X);
    assign w_dy  = {1'b0, y_com_in} - 11'(CENTER_Y);
    assign w_adx = w_dx[11] ? (12'd0 - w_dx) : w_dx;
    assign w_ady = w_dy[10] ? (11'd0 - w_dy) : w_dy;
    assign w_none = (w_adx <= LP_DZ) && ({1'b0, w_ady} <= LP_DZ);

    // Ties between |dx| and |dy| go vertical.
    always_comb begin
        w_dir = DIR_DOWN;
        if (w_adx > {1'b0, w_ady}) begin
            w_dir = w_dx[11] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            w_dir = w_dy[10] ? DIR_UP : DIR_DOWN;
        end
    end

    assign w_cnt_nxt = r_cnt + 4'd1;
    assign w_cd_nxt  = r_cd + 8'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cd        <= 8'd0;
            r_cand      <= 2'b00;
            r_samp_vld  <= 1'b0;
            r_samp_none <= 1'b0;
            r_samp_dir  <= 2'b00;
            r_seen      <= 1'b0;
            r_rot       <= 2'b00;
            r_rot_vld   <= 1'b0;
        end else begin
            r_samp_vld  <= com_valid_in;
            r_samp_none <= w_none;
            r_samp_dir  <= w_dir;
            r_rot_vld   <= 1'b0;

            // A strobe coinciding with frame_start belongs to the frame that is ending.
            if (frame_start_in) begin
                r_seen <= 1'b0;
            end else if (r_samp_vld) begin
                r_seen <= 1'b1;
            end

            if (!enable_in) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
                r_cd    <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_samp_vld && !r_samp_none) begin
                            r_cand <= r_samp_dir;
                            r_cnt  <= 4'd1;
                            if (LP_HOLD == 4'd1) begin
                                r_state   <= S_FIRE;
                                r_rot     <= r_samp_dir;
                                r_rot_vld <= 1'b1;
                            end else begin
                                r_state <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        if (r_samp_vld) begin
                            if (r_samp_none) begin
                                r_state <= S_IDLE;
                                r_cnt   <= 4'd0;
                            end else if (r_samp_dir == r_cand) begin
                                r_cnt <= w_cnt_nxt;
                                if (w_cnt_nxt == LP_HOLD) begin
                                    r_state   <= S_FIRE;
                                    r_rot     <= r_cand;
                                    r_rot_vld <= 1'b1;
                                end
                            end else begin
                                r_cand <= r_samp_dir;
                                r_cnt  <= 4'd1;
                            end
                        end else if (frame_start_in && !r_seen) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 4'd0;
                        end
                    end
                    S_FIRE: begin
                        r_state <= S_COOLDOWN;
                        r_cd    <= 8'd0;
                    end
                    S_COOLDOWN: begin
                        if (frame_start_in) begin
                            r_cd <= w_cd_nxt;
                            if (w_cd_nxt == LP_CD) begin
                                r_state <= S_WAIT_CENTER;
                            end
                        end
                    end
                    S_WAIT_CENTER: begin
                        if (r_samp_vld && r_samp_none) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rotate_out       = r_rot;
    assign rotate_valid_out = r_rot_vld;
    assign state_out        = r_state;

endmodule

// File: tb/tb_com_gesture_ctrl.sv
// Directed bench for com_gesture_ctrl: hold/fire, direction change, boundaries, cooldown, missed frames, disruption.
module tb_com_gesture_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        enable_in;
    logic        frame_start_in;
    logic        com_valid_in;
    logic [10:0] x_com_in;
    logic [9:0]  y_com_in;
    logic [1:0]  rotate_out;
    logic        rotate_valid_out;
    logic [2:0]  state_out;

    int checks = 0;
    int errors = 0;
    int fires = 0;
    int exp_fires = 0;
    int dbl_vld = 0;
    int spacing_bad = 0;
    int fs_since = 0;
    bit prev_vld = 0;

    com_gesture_ctrl dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .frame_start_in  (frame_start_in),
        .com_valid_in    (com_valid_in),
        .x_com_in        (x_com_in),
        .y_com_in        (y_com_in),
        .rotate_out      (rotate_out),
        .rotate_valid_out(rotate_valid_out),
        .state_out       (state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (frame_start_in) fs_since++;
    end

    always @(negedge clk_in) begin
        if (rotate_valid_out) begin
            if (prev_vld) dbl_vld++;
            if (fires > 0 && fs_since < 16) spacing_bad++;
            fires++;
            fs_since = 0;
        end
        prev_vld = rotate_valid_out;
    end

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [10:0] x, input logic [9:0] y, input bit has_sample);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        tick();
        if (has_sample) begin
            x_com_in     = x;
            y_com_in     = y;
            com_valid_in = 1'b1;
        end
        tick();
        com_valid_in = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Sample strobe lands on the cycle of the next frame's frame_start.
    task automatic late_frame(input logic [10:0] x, input logic [9:0] y);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        tick();
        x_com_in     = x;
        y_com_in     = y;
        com_valid_in = 1'b1;
        tick();
        com_valid_in = 1'b0;
    endtask

    task automatic frames(input int n, input logic [10:0] x, input logic [9:0] y);
        for (int i = 0; i < n; i++) do_frame(x, y, 1'b1);
    endtask

    task automatic recentre(input string tag);
        for (int i = 0; i < 16; i++) do_frame(11'd0, 10'd0, 1'b0);
        do_frame(11'd512, 10'd384, 1'b1);
        chk(tag, state_out, 0);
    endtask

    initial begin
        rst_in         = 1'b1;
        enable_in      = 1'b1;
        frame_start_in = 1'b0;
        com_valid_in   = 1'b0;
        x_com_in       = 11'd0;
        y_com_in       = 10'd0;
        tick();
        tick();
        chk("reset_state", state_out, 0);
        chk("reset_rot", rotate_out, 0);
        chk("reset_vld", rotate_valid_out, 0);
        rst_in = 1'b0;
        tick();

        // Right hold with exact strobe timing
        frames(3, 11'd800, 10'd384);
        chk("right_arm", state_out, 1);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        x_com_in     = 11'd800;
        y_com_in     = 10'd384;
        com_valid_in = 1'b1;
        tick();
        com_valid_in = 1'b0;
        chk("right_vld_early", rotate_valid_out, 0);
        tick();
        chk("right_vld", rotate_valid_out, 1);
        chk("right_rot", rotate_out, 2);
        chk("right_fire_state", state_out, 2);
        tick();
        chk("right_vld_drop", rotate_valid_out, 0);
        chk("right_cooldown", state_out, 3);
        exp_fires = 1;
        chk("right_fires", fires, exp_fires);

        for (int i = 0; i < 15; i++) do_frame(11'd0, 10'd0, 1'b0);
        chk("cd_15", state_out, 3);
        do_frame(11'd800, 10'd384, 1'b1);
        chk("cd_16_wait", state_out, 4);
        do_frame(11'd800, 10'd384, 1'b1);
        chk("wait_ignores_dir", state_out, 4);
        do_frame(11'd512, 10'd384, 1'b1);
        chk("wait_none_idle", state_out, 0);

        // Direction change: up then left
        frames(2, 11'd512, 10'd100);
        chk("up_arm", state_out, 1);
        frames(3, 11'd100, 10'd384);
        chk("left_3_nofire", fires, exp_fires);
        frames(1, 11'd100, 10'd384);
        exp_fires++;
        chk("left_fire", fires, exp_fires);
        chk("left_rot", rotate_out, 3);
        recentre("left_recentre");

        // Boundaries
        frames(4, 11'd608, 10'd480);
        chk("dz_edge_idle", state_out, 0);
        chk("dz_edge_nofire", fires, exp_fires);
        frames(4, 11'd609, 10'd384);
        exp_fires++;
        chk("dz_out_fire", fires, exp_fires);
        chk("dz_out_rot", rotate_out, 2);
        recentre("dz_recentre");
        frames(4, 11'd700, 10'd572);
        exp_fires++;
        chk("tie_fire", fires, exp_fires);
        chk("tie_rot_down", rotate_out, 1);
        recentre("tie_recentre");

        // Long hold then re-centre
        frames(30, 11'd800, 10'd384);
        exp_fires++;
        chk("hold30_fires", fires, exp_fires);
        chk("hold30_wait", state_out, 4);
        do_frame(11'd512, 10'd384, 1'b1);
        chk("hold30_idle", state_out, 0);
        frames(4, 11'd800, 10'd384);
        exp_fires++;
        chk("hold30_refire", fires, exp_fires);
        recentre("hold30_recentre");

        // Missed frame
        frames(3, 11'd800, 10'd384);
        do_frame(11'd0, 10'd0, 1'b0);
        chk("miss_still_arm", state_out, 1);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        chk("miss_idle", state_out, 0);
        frames(3, 11'd800, 10'd384);
        chk("miss_fresh_nofire", fires, exp_fires);
        frames(1, 11'd800, 10'd384);
        exp_fires++;
        chk("miss_fresh_fire", fires, exp_fires);
        recentre("miss_recentre");

        // Coincident sample and frame_start
        for (int i = 0; i < 4; i++) late_frame(11'd100, 10'd384);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        tick();
        exp_fires++;
        chk("coinc_fire", fires, exp_fires);
        chk("coinc_rot", rotate_out, 3);
        recentre("coinc_recentre");

        // Reset mid-ARM
        frames(3, 11'd800, 10'd384);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rst_arm_state", state_out, 0);
        chk("rst_arm_rot", rotate_out, 0);
        frames(3, 11'd800, 10'd384);
        chk("rst_fresh_nofire", fires, exp_fires);
        frames(1, 11'd800, 10'd384);
        exp_fires++;
        chk("rst_fresh_fire", fires, exp_fires);
        recentre("rst_recentre");

        // Reset on the would-be FIRE edge
        frames(3, 11'd800, 10'd384);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        x_com_in     = 11'd800;
        y_com_in     = 10'd384;
        com_valid_in = 1'b1;
        tick();
        com_valid_in = 1'b0;
        rst_in       = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("rst_fire_vld", rotate_valid_out, 0);
        chk("rst_fire_state", state_out, 0);
        tick();
        chk("rst_fire_nofire", fires, exp_fires);

        // Enable dropped in ARM; rotate_out must hold
        frames(1, 11'd100, 10'd384);
        frames(3, 11'd100, 10'd384);
        exp_fires++;
        chk("en_pre_fire", fires, exp_fires);
        recentre("en_recentre");
        frames(3, 11'd800, 10'd384);
        chk("en_arm", state_out, 1);
        enable_in = 1'b0;
        tick();
        chk("en_off_idle", state_out, 0);
        frames(4, 11'd800, 10'd384);
        chk("en_off_nofire", fires, exp_fires);
        chk("en_off_hold_rot", rotate_out, 3);
        chk("en_off_state", state_out, 0);
        enable_in = 1'b1;
        frames(3, 11'd800, 10'd384);
        chk("en_on_nofire", fires, exp_fires);
        frames(1, 11'd800, 10'd384);
        exp_fires++;
        chk("en_on_fire", fires, exp_fires);
        chk("en_on_rot", rotate_out, 2);

        tick();
        chk("no_double_strobe", dbl_vld, 0);
        chk("strobe_spacing", spacing_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
